// File: rtl/cordic_sequencer.sv
// Iterative rotation-mode CORDIC controller: pre-rotates a job into [-90,+90) and walks the atan LUT, one step per cycle.
// Latency: ITERATIONS cycles from accept edge to out_valid; minimum job period ITERATIONS+2 cycles.
// Backpressure: in_ready only in IDLE; result holds in DONE until out_ready. Optional gain compensation: CORDIC_GAIN_COMP_EN.
module cordic_sequencer #(
  parameter int BIT_WIDTH   = 32,
  parameter int INPUT_WIDTH = 5,
  parameter int ITERATIONS  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BIT_WIDTH-1:0]   in_angle,
  input  logic [BIT_WIDTH-1:0]   in_x,
  input  logic [BIT_WIDTH-1:0]   in_y,
  output logic [INPUT_WIDTH-1:0] lut_index,
  input  logic [BIT_WIDTH-1:0]   lut_value,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIT_WIDTH-1:0]   out_x,
  output logic [BIT_WIDTH-1:0]   out_y,
  output logic [BIT_WIDTH-1:0]   out_angle,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  localparam logic [INPUT_WIDTH-1:0] LAST_IDX  = INPUT_WIDTH'(ITERATIONS - 1);
  localparam logic [BIT_WIDTH-1:0]   HALF_TURN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  state_t                  state, state_nxt;
  logic signed [BIT_WIDTH-1:0] x_q, y_q, z_q;
  logic [INPUT_WIDTH-1:0]  idx_q;
  logic                    accept;

  logic [BIT_WIDTH-1:0]    src_x, src_y;
  logic [BIT_WIDTH-1:0]    load_x, load_y, load_z;
  logic                    flip;
  logic signed [BIT_WIDTH-1:0] sh_x, sh_y;
  logic [BIT_WIDTH-1:0]    step_x, step_y, step_z;
  logic                    rot_pos;

`ifdef CORDIC_GAIN_COMP_EN
  // Start vector pre-divided by the CORDIC gain K so the result lands on (cos, sin).
  localparam real                  K_INV  = 0.6072529350088812;
  localparam logic [BIT_WIDTH-1:0] GAIN_X = BIT_WIDTH'(longint'(K_INV * (2.0 ** (BIT_WIDTH - 2))));
  assign src_x = GAIN_X;
  assign src_y = '0;
`else
  assign src_x = in_x;
  assign src_y = in_y;
`endif

  // Quadrants 01 and 10 lie outside +/-90 deg: rotate by 180 deg up front so z converges.
  always_comb begin
    flip   = in_angle[BIT_WIDTH-1] ^ in_angle[BIT_WIDTH-2];
    load_x = flip ? (BIT_WIDTH'(0) - src_x) : src_x;
    load_y = flip ? (BIT_WIDTH'(0) - src_y) : src_y;
    load_z = flip ? (in_angle - HALF_TURN) : in_angle;
  end

  // One micro-rotation: direction follows the sign of the residual angle.
  always_comb begin
    rot_pos = ~z_q[BIT_WIDTH-1];
    sh_y    = y_q >>> idx_q;
    sh_x    = x_q >>> idx_q;
    step_x  = rot_pos ? BIT_WIDTH'(x_q - sh_y) : BIT_WIDTH'(x_q + sh_y);
    step_y  = rot_pos ? BIT_WIDTH'(y_q + sh_x) : BIT_WIDTH'(y_q - sh_x);
    step_z  = rot_pos ? BIT_WIDTH'(z_q - $signed(lut_value)) : BIT_WIDTH'(z_q + $signed(lut_value));
  end

  // Next-state and handshake outputs; LUT index is only driven while iterating.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    lut_index = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ITER;
        end
      end
      ITER: begin
        busy      = 1'b1;
        lut_index = idx_q;
        if (idx_q == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any job in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      idx_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        x_q   <= load_x;
        y_q   <= load_y;
        z_q   <= load_z;
        idx_q <= '0;
      end else if (state == ITER) begin
        x_q   <= step_x;
        y_q   <= step_y;
        z_q   <= step_z;
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_angle = z_q;

endmodule
